// File: rtl/jag_lightpen_latch_if.sv
// jag_lightpen_latch_if: register-file read port
// of the light-pen capture block.
interface jag_lightpen_latch_if;
  logic        rd_stb;
  logic [1:0]  rd_addr;
  logic [15:0] rd_data;
  logic        rd_ack;

  modport master (
    output rd_stb,
    output rd_addr,
    input  rd_data,
    input  rd_ack
  );

  modport slave (
    input  rd_stb,
    input  rd_addr,
    output rd_data,
    output rd_ack
  );
endinterface

// File: rtl/jag_lightpen_latch.sv
// jag_lightpen_latch: first-strike light-pen beam capture (xvclk).
// Define LP_HIT_AVG_EN to average up to 4 strikes per frame.
module jag_lightpen_latch #(
  parameter int SYNC_STAGES  = 2,
  parameter int X_COMP       = 0,
  parameter int HOLDOFF_CLKS = 128
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                lp0,
  input  logic                lp1,
  input  logic [1:0]          port_mask,
  input  logic [11:0]         cycle,
  input  logic [9:0]          scanline,
  input  logic                vsync,
  jag_lightpen_latch_if.slave rd,
  output logic                irq
);
  localparam int HW =
    (HOLDOFF_CLKS > 2) ? $clog2(HOLDOFF_CLKS) : 1;
  localparam logic [HW-1:0] HOLD_INIT =
    HW'(HOLDOFF_CLKS - 1);
  localparam logic [11:0] XC = 12'(X_COMP);

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    LATCHED
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync0_q, sync1_q;
  logic [1:0]             mprev_q;
  logic                   vs_q;
  logic [HW-1:0]          hold_q, hold_d;
  logic [11:0]            lph_q, lph_d;
  logic [9:0]             lpv_q, lpv_d;
  logic                   hit_q, hit_d;
  logic                   ovr_q, ovr_d;
  logic                   nohit_q, nohit_d;
  logic                   pid_q, pid_d;
  logic                   irq_q, irq_d;
  logic                   ack_q;
  logic [1:0]             addr_q;
  logic [1:0]             lpm;
  logic                   edge0, edge1;
  logic                   strike, vs_rise;
  logic                   clr, cap;
  logic                   ov_set, nh_set;
  logic [11:0]            cyc_adj;
  logic                   avg_done;
  logic [11:0]            avg_x;
  logic [9:0]             avg_y;

  // Synchronise pen inputs and keep edge history.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync0_q <= '0;
      sync1_q <= '0;
      mprev_q <= '0;
      vs_q    <= 1'b0;
    end else begin
      sync0_q[0] <= lp0;
      sync1_q[0] <= lp1;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync0_q[i] <= sync0_q[i-1];
        sync1_q[i] <= sync1_q[i-1];
      end
      mprev_q <= lpm;
      vs_q    <= vsync;
    end
  end

  assign lpm = {sync1_q[SYNC_STAGES-1],
                sync0_q[SYNC_STAGES-1]} & port_mask;
  assign edge0   = lpm[0] & ~mprev_q[0];
  assign edge1   = lpm[1] & ~mprev_q[1];
  assign strike  = edge0 | edge1;
  assign vs_rise = vsync & ~vs_q;
  assign cyc_adj = (cycle >= XC) ? cycle - XC : '0;
  assign clr     = ack_q & (addr_q == 2'd2);

  // Frame FSM, status flags and capture selection.
  always_comb begin
    state_d = state_q;
    hold_d  = (hold_q != '0) ? hold_q - 1'b1 : hold_q;
    cap     = 1'b0;
    ov_set  = 1'b0;
    nh_set  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (vs_rise) state_d = ARMED;
      end
      ARMED: begin
        if (strike) begin
          cap     = 1'b1;
          ov_set  = hit_q;
          hold_d  = HOLD_INIT;
          state_d = LATCHED;
        end else if (vs_rise) begin
          nh_set = 1'b1;
        end
      end
      LATCHED: begin
        if (vs_rise) begin
          state_d = ARMED;
          hold_d  = '0;
        end else if (strike && hold_q == '0) begin
          ov_set = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    hit_d   = cap | (hit_q & ~clr);
    ovr_d   = ov_set | (ovr_q & ~clr);
    nohit_d = nh_set | (nohit_q & ~clr);
    pid_d   = cap ? ~edge0 : pid_q;
    lph_d   = lph_q;
    lpv_d   = lpv_q;
    if (cap) begin
      lph_d = cyc_adj;
      lpv_d = scanline;
    end else if (avg_done) begin
      lph_d = avg_x;
      lpv_d = avg_y;
    end
    irq_d = cap | avg_done;
  end

  // State and capture registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      hold_q  <= '0;
      lph_q   <= '0;
      lpv_q   <= '0;
      hit_q   <= 1'b0;
      ovr_q   <= 1'b0;
      nohit_q <= 1'b0;
      pid_q   <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      lph_q   <= lph_d;
      lpv_q   <= lpv_d;
      hit_q   <= hit_d;
      ovr_q   <= ovr_d;
      nohit_q <= nohit_d;
      pid_q   <= pid_d;
      irq_q   <= irq_d;
    end
  end

  // Read strobe pipeline: ack one clock after strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      ack_q  <= 1'b0;
      addr_q <= '0;
    end else begin
      ack_q <= rd.rd_stb;
      if (rd.rd_stb) addr_q <= rd.rd_addr;
    end
  end

  // Read data mux, zero outside the ack cycle.
  always_comb begin
    rd.rd_data = '0;
    if (ack_q) begin
      unique case (addr_q)
        2'd0:    rd.rd_data = {4'b0, lph_q};
        2'd1:    rd.rd_data = {6'b0, lpv_q};
        2'd2:    rd.rd_data = {12'b0, pid_q, nohit_q,
                               ovr_q, hit_q};
        default: rd.rd_data = '0;
      endcase
    end
  end

  assign rd.rd_ack = ack_q;
  assign irq       = irq_q;

`ifdef LP_HIT_AVG_EN
  logic [13:0] sumx_q, sumx_d;
  logic [11:0] sumy_q, sumy_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        acc_en;

  // Divide by 1..4; 43691/2^17 is exact for s < 2^17.
  function automatic logic [11:0] div_cnt(
    input logic [13:0] s,
    input logic [2:0]  c
  );
    logic [31:0] w;
    unique case (c)
      3'd2:    w = {18'b0, s} >> 1;
      3'd3:    w = ({18'b0, s} * 32'd43691) >> 17;
      3'd4:    w = {18'b0, s} >> 2;
      default: w = {18'b0, s};
    endcase
    return 12'(w);
  endfunction

  // Accumulate strikes of the frame; vsync restarts.
  always_comb begin
    acc_en = strike && (cnt_q < 3'd4) &&
             ((state_q == ARMED) ||
              (state_q == LATCHED && !vs_rise));
    sumx_d = sumx_q;
    sumy_d = sumy_q;
    cnt_d  = cnt_q;
    if (vs_rise) begin
      sumx_d = '0;
      sumy_d = '0;
      cnt_d  = '0;
    end
    if (acc_en) begin
      sumx_d = sumx_d + 14'(cyc_adj);
      sumy_d = sumy_d + 12'(scanline);
      cnt_d  = cnt_d + 3'd1;
    end
  end

  // Accumulator registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      sumx_q <= '0;
      sumy_q <= '0;
      cnt_q  <= '0;
    end else begin
      sumx_q <= sumx_d;
      sumy_q <= sumy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign avg_done = vs_rise && (state_q == LATCHED) &&
                    (cnt_q != 3'd0);
  assign avg_x = div_cnt(sumx_q, cnt_q);
  assign avg_y = 10'(div_cnt({2'b0, sumy_q}, cnt_q));
`else
  assign avg_done = 1'b0;
  assign avg_x    = '0;
  assign avg_y    = '0;
`endif
endmodule

// File: doc/jag_lightpen_latch.md
Name: jag_lightpen_latch

Overview:
- Downstream consumer of the lightgun pulse outputs (lp0/lp1), located in the video (xvclk) domain.
- Detects the first light-pen strike of each frame and freezes the current beam position into LPH/LPV capture registers.
- Exposes the captured position plus status through a small single-cycle read port to the register file.
- Raises a one-cycle interrupt pulse on each capture.

Parameters:
- SYNC_STAGES, 2: flop stages on lp0/lp1 before edge detection (minimum 1).
- X_COMP, 0: beam-clock count subtracted from the captured cycle to compensate pipeline delay.
- HOLDOFF_CLKS, 128: clocks after a capture during which further edges are ignored for overrun purposes.

Ports:
- clk in 1: video clock (xvclk).
- reset in 1: synchronous, active-high.
- lp0 in 1: light pen pulse, port 0.
- lp1 in 1: light pen pulse, port 1.
- port_mask in 2: bit n enables lp<n>.
- cycle in 12: beam X in video clocks.
- scanline in 10: beam Y in lines.
- vsync in 1: active-high vertical sync.
- rd_stb in 1: one-cycle read request.
- rd_addr in 2: 0=LPH, 1=LPV, 2=STATUS, 3=reserved.
- rd_data out 16: read data, valid while rd_ack=1.
- rd_ack out 1: one-cycle acknowledge, the cycle after rd_stb.
- irq out 1: one-cycle pulse on capture.

Behaviour:
- Reset: every output is 0. All registers (lph, lpv, hit, overrun, nohit, port_id, holdoff counter) are 0. State = IDLE.
- Input path: each lp<n> passes through SYNC_STAGES flops, is ANDed with port_mask[n], then rising-edge detected. Edge latency is SYNC_STAGES+1 clocks from the input rising edge.
- strike = edge0 | edge1. If both fire in the same cycle, port_id=0 wins.
- vsync_rise is detected with a one-flop history.
- FSM:
  - IDLE: on vsync_rise -> ARMED.
  - ARMED, on strike:
    - lph <= {4'b0, cycle - X_COMP}, saturating at 0 when cycle < X_COMP.
    - lpv <= {6'b0, scanline}.
    - port_id <= edge source.
    - If hit is already 1 (unread), set overrun.
    - Set hit, pulse irq for 1 clock, load holdoff counter with HOLDOFF_CLKS-1, go to LATCHED.
  - ARMED, on vsync_rise with no strike: set nohit, stay ARMED.
  - LATCHED: the holdoff counter decrements to 0. A strike while the counter is 0 sets overrun; captured values do not change. On vsync_rise -> ARMED and the holdoff counter clears.
- Simultaneous strike and vsync_rise in ARMED: the strike is captured and the FSM goes to LATCHED. The vsync is not counted as a miss.
- Simultaneous strike and vsync_rise in LATCHED: go to ARMED, strike ignored.
- The captured value is the cycle/scanline sampled on the edge-detect cycle. No further delay is added.
- Read port:
  - rd_stb registers rd_addr. rd_ack=1 and rd_data are valid the next clock.
  - LPH returns lph; LPV returns lpv.
  - STATUS returns {12'b0, port_id, nohit, overrun, hit}.
  - Reserved address returns 0.
  - A STATUS read clears hit, overrun and nohit in the ack cycle.
  - If a capture sets hit in that same cycle, hit=1 and overrun follow capture rules; set beats clear.
  - LPH/LPV reads are side-effect free.
  - Back-to-back rd_stb is legal: one ack per strobe, pipelined.
- Reset mid-read: the ack is dropped.
- Reset mid-holdoff: return to IDLE. A capture requires a vsync_rise after reset.

Optional Feature:
- Macro LP_HIT_AVG_EN.
- When defined:
  - In ARMED and LATCHED, each strike (holdoff ignored) up to 4 per frame accumulates cycle_adj and scanline into 14-bit and 12-bit sums and increments a 3-bit count.
  - On vsync_rise with count>0, lph/lpv are overwritten with sum/count (truncating; divide-by-3 via constant reciprocal or small iterative divider finished within 16 clocks).
  - The averaged result is readable after completion, and irq pulses again on completion.
  - Overrun semantics are unchanged for the first capture.
- When undefined: first-strike-only capture, no accumulators.

Test Plan:
- Reset, vsync_rise, lp0 pulse at cycle=600, scanline=130, port_mask=01, X_COMP=0 -> irq one clock, SYNC_STAGES+1 clocks after pulse. Reads: LPH=600, LPV=130, STATUS=0x0001. A second STATUS read returns 0x0000.
- port_mask=10, pulses on lp0 then lp1 at (700,90) -> only lp1 captured. LPH=700, LPV=90, STATUS=0x0009 (port_id=1).
- Frame with no pulse followed by vsync_rise -> STATUS=0x0004 (nohit). A pulse in the next frame gives 0x0005.
- Capture in frame N unread, capture in frame N+1 at (400,50) -> LPH=400, STATUS=0x0003. A second pulse 200 clocks after capture in the same frame also sets overrun; 50 clocks after does not.
- X_COMP=16, pulse at cycle=10 -> LPH=0 (saturated). Pulse at cycle=100 -> LPH=84.
- Strike and vsync_rise in the same cycle while ARMED -> captured, state LATCHED, nohit stays 0. With LP_HIT_AVG_EN, strikes at X 100/104/108/112 -> LPH=106 after vsync.
